// File: rtl/stoch_signed_col_matvec_if.sv
// Handshake and data bundle for the signed stochastic im2col matrix-vector block.
// The block that accumulates takes the slave modport. The block that feeds and drains it takes the master modport.
interface stoch_signed_col_matvec_if #(
    parameter int COL_HEIGHT = 16,
    parameter int COL_WIDTH  = 27,
    parameter int STREAM_LEN = 256
);
    localparam int ACC_W = $clog2(2*COL_WIDTH*STREAM_LEN+1)+1;

    // Two handshakes are in use. A beat is taken on an edge where in_valid && in_ready.
    // A result is released on an edge where out_valid && out_ready.
    // Neither valid depends combinationally on its ready.
    logic                                 start;
    logic                                 in_valid;
    logic                                 in_ready;
    logic [COL_HEIGHT-1:0][COL_WIDTH-1:0] col_p;
    logic [COL_HEIGHT-1:0][COL_WIDTH-1:0] col_m;
    logic [COL_WIDTH-1:0]                 w_p;
    logic [COL_WIDTH-1:0]                 w_m;
    logic                                 out_valid;
    logic                                 out_ready;
    logic [COL_HEIGHT-1:0][ACC_W-1:0]     acc;
    logic                                 busy;

    modport master (
        output start, in_valid, col_p, col_m, w_p, w_m, out_ready,
        input  in_ready, out_valid, acc, busy
    );

    modport slave (
        input  start, in_valid, col_p, col_m, w_p, w_m, out_ready,
        output in_ready, out_valid, acc, busy
    );
endinterface

// File: rtl/stoch_signed_col_matvec.sv
// Accumulates signed (dual-rail) bitstream dot products of each im2col row against a weight beat,
// over STREAM_LEN accepted beats, then presents the result until it is taken.
module stoch_signed_col_matvec #(
    parameter int COL_HEIGHT = 16,
    parameter int COL_WIDTH  = 27,
    parameter int STREAM_LEN = 256
) (
    input  logic                        CLK,
    input  logic                        nRST,
    stoch_signed_col_matvec_if.slave    bus,
    output logic [1:0]                  o_state
);
    localparam int ACC_W = $clog2(2*COL_WIDTH*STREAM_LEN+1)+1;
    localparam int CNT_W = (STREAM_LEN > 1) ? $clog2(STREAM_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(STREAM_LEN-1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                           r_state;
    state_t                           w_next_state;
    logic                             w_accept;
    logic                             w_clear;
    logic [CNT_W-1:0]                 r_cnt;
    logic [COL_HEIGHT-1:0][ACC_W-1:0] r_acc;
    logic [ACC_W-1:0]                 w_delta [COL_HEIGHT];

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_clear      = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_next_state = ACCUM;
                    w_clear      = 1'b1;
                end
            end
            ACCUM: begin
                if (bus.in_valid) begin
                    w_accept = 1'b1;
                    if (r_cnt == LAST_BEAT) begin
                        w_next_state = DONE;
                    end
                end
            end
            DONE: begin
                // start is deliberately ignored here: a new window needs start seen in IDLE
                if (bus.out_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // pos - neg per row, built bit by bit in modular ACC_W arithmetic so the sign extends for free
    always_comb begin
        for (int r = 0; r < COL_HEIGHT; r++) begin
            w_delta[r] = '0;
            for (int b = 0; b < COL_WIDTH; b++) begin
                w_delta[r] = w_delta[r]
                           + ACC_W'(bus.col_p[r][b] & bus.w_p[b])
                           + ACC_W'(bus.col_m[r][b] & bus.w_m[b])
                           - ACC_W'(bus.col_p[r][b] & bus.w_m[b])
                           - ACC_W'(bus.col_m[r][b] & bus.w_p[b]);
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_cnt <= '0;
            r_acc <= '0;
        end else if (w_clear) begin
            r_cnt <= '0;
            r_acc <= '0;
        end else if (w_accept) begin
            r_cnt <= r_cnt + CNT_W'(1);
            for (int r = 0; r < COL_HEIGHT; r++) begin
                r_acc[r] <= r_acc[r] + w_delta[r];
            end
        end
    end

    assign bus.in_ready  = (r_state == ACCUM);
    assign bus.out_valid = (r_state == DONE);
    assign bus.busy      = (r_state != IDLE);
    assign bus.acc       = r_acc;
    assign o_state       = r_state;
endmodule

// File: tb/tb_stoch_signed_col_matvec.sv
// Directed bench for stoch_signed_col_matvec with a result scoreboard and directed control checks.
module tb_stoch_signed_col_matvec;
    localparam int CH = 2;
    localparam int CW = 4;
    localparam int SL = 4;
    localparam int AW = $clog2(2*CW*SL+1)+1;

    logic CLK;
    logic nRST;
    logic [1:0] o_state;
    int n_checks = 0;
    int n_fail   = 0;
    logic [2*AW-1:0] exp_q[$];
    logic prev_ov = 1'b0;

    stoch_signed_col_matvec_if #(.COL_HEIGHT(CH), .COL_WIDTH(CW), .STREAM_LEN(SL)) bus ();

    stoch_signed_col_matvec #(.COL_HEIGHT(CH), .COL_WIDTH(CW), .STREAM_LEN(SL)) dut (
        .CLK     (CLK),
        .nRST    (nRST),
        .bus     (bus),
        .o_state (o_state)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [2*AW-1:0] pk(input int a0, input int a1);
        logic [AW-1:0] v0;
        logic [AW-1:0] v1;
        v0 = AW'(a0);
        v1 = AW'(a1);
        return {v1, v0};
    endfunction

    // Monitor: compares each new result against the oldest expected one
    always @(negedge CLK) begin
        if (bus.out_valid && !prev_ov) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_result: got %0h expected none at %0t", bus.acc, $time);
            end else begin
                chk("result", 64'(bus.acc), 64'(exp_q.pop_front()));
            end
        end
        prev_ov = bus.out_valid;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_beat(input logic v, input logic [3:0] p0, input logic [3:0] m0,
                            input logic [3:0] p1, input logic [3:0] m1,
                            input logic [3:0] wp, input logic [3:0] wm);
        bus.in_valid = v;
        bus.col_p[0] = p0;
        bus.col_m[0] = m0;
        bus.col_p[1] = p1;
        bus.col_m[1] = m1;
        bus.w_p      = wp;
        bus.w_m      = wm;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic run_window(input logic [3:0] p0, input logic [3:0] m0,
                              input logic [3:0] p1, input logic [3:0] m1,
                              input logic [3:0] wp, input logic [3:0] wm,
                              input int a0, input int a1, input string name);
        exp_q.push_back(pk(a0, a1));
        do_start();
        chk({name, "_in_ready"}, 64'(bus.in_ready), 64'd1);
        for (int i = 0; i < SL; i++) begin
            chk({name, "_no_early_valid"}, 64'(bus.out_valid), 64'd0);
            set_beat(1'b1, p0, m0, p1, m1, wp, wm);
            tick();
        end
        set_beat(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        chk({name, "_out_valid"}, 64'(bus.out_valid), 64'd1);
    endtask

    task automatic release_result();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("release_idle", 64'(o_state), 64'd0);
    endtask

    initial begin
        nRST = 1'b0;
        bus.start = 1'b0;
        bus.out_ready = 1'b0;
        set_beat(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        repeat (3) tick();
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_acc", 64'(bus.acc), 64'd0);
        chk("rst_state", 64'(o_state), 64'd0);
        nRST = 1'b1;
        tick();

        // All-positive stream: 4 matches per beat, 4 beats
        run_window(4'hF, 4'h0, 4'hF, 4'h0, 4'hF, 4'h0, 16, 16, "plus");
        release_result();

        // Row0 hits negative weights twice per beat, row1 minus rail matches one minus weight bit
        run_window(4'hF, 4'h0, 4'h0, 4'h1, 4'h0, 4'h3, -8, 4, "signed");
        release_result();

        // Beats offered in IDLE must not touch the held result
        set_beat(1'b1, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'h0);
        tick();
        tick();
        chk("idle_in_ready", 64'(bus.in_ready), 64'd0);
        chk("idle_acc_held", 64'(bus.acc), 64'(pk(-8, 4)));
        set_beat(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);

        // Toggling valid: row0 delta +2, row1 delta -2 per valid beat; gap beats carry junk
        exp_q.push_back(pk(8, -8));
        do_start();
        for (int i = 0; i < 7; i++) begin
            if (i % 2 == 0) set_beat(1'b1, 4'b1010, 4'b0101, 4'b0011, 4'b1100, 4'b1110, 4'b0001);
            else            set_beat(1'b0, 4'hF, 4'h0, 4'hF, 4'h0, 4'hF, 4'h0);
            if (i == 6) chk("toggle_not_done", 64'(bus.out_valid), 64'd0);
            tick();
        end
        set_beat(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        chk("toggle_out_valid", 64'(bus.out_valid), 64'd1);

        // Hold in DONE with start and in_valid pressing
        for (int i = 0; i < 5; i++) begin
            bus.start = 1'b1;
            set_beat(1'b1, 4'hF, 4'h0, 4'hF, 4'h0, 4'hF, 4'h0);
            tick();
            chk("hold_out_valid", 64'(bus.out_valid), 64'd1);
            chk("hold_acc", 64'(bus.acc), 64'(pk(8, -8)));
            chk("hold_state", 64'(o_state), 64'd2);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.out_ready = 1'b0;
        set_beat(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        chk("done_start_goes_idle", 64'(o_state), 64'd0);
        chk("done_exit_out_valid", 64'(bus.out_valid), 64'd0);
        tick();
        chk("idle_stays_idle", 64'(bus.busy), 64'd0);
        chk("idle_acc_retained", 64'(bus.acc), 64'(pk(8, -8)));

        // Asynchronous reset mid-window discards the partial sum
        do_start();
        set_beat(1'b1, 4'hF, 4'h0, 4'hF, 4'h0, 4'hF, 4'h0);
        tick();
        tick();
        chk("pre_rst_acc", 64'(bus.acc), 64'(pk(8, 8)));
        #2 nRST = 1'b0;
        #1;
        chk("async_rst_acc", 64'(bus.acc), 64'd0);
        chk("async_rst_busy", 64'(bus.busy), 64'd0);
        chk("async_rst_in_ready", 64'(bus.in_ready), 64'd0);
        tick();
        nRST = 1'b1;
        for (int i = 0; i < 8; i++) begin
            set_beat(i[0], 4'hF, 4'h0, 4'hF, 4'h0, 4'hF, 4'h0);
            tick();
            chk("post_rst_no_out_valid", 64'(bus.out_valid), 64'd0);
        end
        chk("post_rst_state", 64'(o_state), 64'd0);
        set_beat(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);

        // Every rail set: plus and minus contributions cancel exactly
        run_window(4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 0, 0, "cancel");
        release_result();
        run_window(4'hF, 4'h0, 4'hF, 4'h0, 4'hF, 4'h0, CW*SL, CW*SL, "max");
        release_result();

        tick();
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/stoch_signed_col_matvec.md
STOCH_SIGNED_COL_MATVEC -- requirements
Module: stoch_signed_col_matvec

Interface
REQ-001 The block SHALL have parameter COL_HEIGHT, default 16: number of im2col rows (output channels of partial dot products) presented per cycle.
REQ-002 The block SHALL have parameter COL_WIDTH, default 27: bits per im2col row (KERNEL_H*KERNEL_W*CHANNELS).
REQ-003 The block SHALL have parameter STREAM_LEN, default 256: bitstream beats accumulated per result.
REQ-004 The block SHALL have localparam ACC_W = $clog2(2*COL_WIDTH*STREAM_LEN+1)+1: signed accumulator width.
REQ-005 The block SHALL have port CLK  input  1  single clock, all state updates on rising edge.
REQ-006 The block SHALL have port nRST  input  1  reset, asynchronous and active-low.
REQ-007 The block SHALL have port start  input  1  begin a new accumulation window.
REQ-008 The block SHALL have port in_valid  input  1  current col/weight beat is valid.
REQ-009 The block SHALL have port in_ready  output  1  block accepts a beat this cycle.
REQ-010 The block SHALL have port col_p, col_m  input  [COL_HEIGHT-1:0][COL_WIDTH-1:0] each  plus/minus rails of one im2col bitstream beat.
REQ-011 The block SHALL have port w_p, w_m  input  [COL_WIDTH-1:0] each  plus/minus rails of the weight bitstream beat.
REQ-012 The block SHALL have port out_valid  output  1  acc holds a completed result.
REQ-013 The block SHALL have port out_ready  input  1  consumer takes the result.
REQ-014 The block SHALL have port acc  output  [COL_HEIGHT-1:0][ACC_W-1:0]  signed two's-complement accumulated dot products.
REQ-015 The block SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-016 The block SHALL implement the FSM states IDLE, ACCUM and DONE.
REQ-017 In IDLE, start=1 SHALL move the block to ACCUM, clear every acc row to 0 and clear the beat counter to 0 on the same edge.
REQ-018 in_ready SHALL equal (state==ACCUM), combinationally.
REQ-019 A beat SHALL be accepted when in_valid && in_ready; beats with in_valid=1 in IDLE or DONE SHALL be ignored.
REQ-020 For each accepted beat and each row r, the block SHALL form pos = popcount(col_p[r]&w_p) + popcount(col_m[r]&w_m) and neg = popcount(col_p[r]&w_m) + popcount(col_m[r]&w_p).
REQ-021 acc[r] SHALL be updated to acc[r] + pos - neg at the edge that accepts the beat; delta range is [-2*COL_WIDTH, +2*COL_WIDTH] and SHALL be sign-extended to ACC_W, with overflow impossible by construction.
REQ-022 The beat counter SHALL increment on each accepted beat; the cycle with in_valid=0 in ACCUM SHALL leave acc and the counter unchanged.
REQ-023 The accepted beat taken while counter==STREAM_LEN-1 SHALL be accumulated and SHALL move the block to DONE; out_valid SHALL be 1 in the next cycle, giving latency 1 cycle after the last beat.
REQ-024 In DONE, out_valid SHALL be 1 and acc SHALL be held stable until out_ready=1, which SHALL return the block to IDLE on that edge.
REQ-025 acc SHALL retain its value in IDLE until the next start.
REQ-026 start SHALL be ignored in ACCUM and DONE; there is no abort.
REQ-027 When start and out_ready are both 1 in DONE, the block SHALL go to IDLE only, and a new window requires start in IDLE.
REQ-028 out_valid SHALL equal (state==DONE) and SHALL never be asserted in IDLE or ACCUM.

Reset
REQ-029 nRST=0 SHALL asynchronously force state to IDLE, counter to 0, every acc row to 0, out_valid to 0, in_ready to 0 and busy to 0.
REQ-030 Reset asserted mid-ACCUM or in DONE SHALL discard the partial or completed result, with no out_valid pulse after release.
REQ-031 After reset release, the first action SHALL be taken only on a start sampled in IDLE.

Verification
REQ-032 With COL_HEIGHT=2, COL_WIDTH=4, STREAM_LEN=4: start, then 4 beats with col_p=all 1s, col_m=0, w_p=4'b1111, w_m=0 -> out_valid the cycle after beat 4, acc={16,16}.
REQ-033 With the same parameters: row0 col_p=4'b1111, w_m=4'b0011, and row1 col_m=4'b0001, w_m=4'b0001, for 4 beats -> acc[0]=-8, acc[1]=+4.
REQ-034 Beats with in_valid toggling 1,0,1,0,... -> only valid beats counted, and out_valid occurs after the 4th valid beat with acc unchanged by idle cycles.
REQ-035 Hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 and start=1 -> acc stable, out_valid held, no state change; then out_ready=1 -> IDLE next cycle.
REQ-036 Assert nRST=0 after 2 accepted beats -> acc=0, busy=0 immediately; after release with no start, no out_valid ever.
REQ-037 Worst case: every rail 1, all weights 1, STREAM_LEN beats -> acc = 0 (pos=neg=2*COL_WIDTH per beat); with col_m=w_m=0 instead -> acc = COL_WIDTH*STREAM_LEN, with no wrap.
